// File: rtl/rr_grant_indexer_pkg.sv
// Shared definitions for the round-robin grant indexer and its downstream
// 2-to-4 decoder stage.
package rr_grant_indexer_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Modular index arithmetic: base + off, wrapping inside the index width.
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned        off);
        return base + IDX_W'(off);
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin winner search over four requesters, starting
// one position after the last winner and wrapping around.
module rr_pick4
    import rr_grant_indexer_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    // cand[k] is the k-th index visited by the search; rot[k] its request bit.
    logic [N_REQ-1:0]            rot;
    logic [N_REQ-1:0][IDX_W-1:0] cand;

    genvar gi;
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
        assign cand[gi] = idx_add(last, gi + 1);
        assign rot[gi]  = req[cand[gi]];
    end

    // Lowest search position with a request wins; scanning downward lets the
    // earliest position overwrite later ones.
    always_comb begin
        pick = last;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick = cand[k];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_grant_indexer.sv
// Round-robin arbiter for four requesters with a registered grant index,
// valid flag and hold-timer timeout pulse. A one-cycle bubble follows
// every release so the downstream decoder never sees an index change while
// a grant is live.
module rr_grant_indexer
    import rr_grant_indexer_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [IDX_W-1:0] last_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             valid_reg;
    logic             timeout_reg;

    logic [IDX_W-1:0] pick;
    logic             any;
    logic             hold_expired;
    logic             owner_req;
    logic             release_now;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_reg),
        .pick (pick),
        .any  (any)
    );

    // Release conditions for the grant currently held.
    always_comb begin
        hold_expired = (cnt_reg == HOLD_LAST);
        owner_req    = req[idx_reg];
        release_now  = done | ~owner_req | hold_expired;
    end

    // Arbitration FSM with hold counter, last-winner pointer and output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            last_reg    <= IDX_W'(N_REQ - 1);
            idx_reg     <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    timeout_reg <= 1'b0;
                    if (any) begin
                        idx_reg   <= pick;
                        last_reg  <= pick;
                        valid_reg <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        valid_reg   <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= ST_IDLE;
                        // Only a pure timer expiry is reported as a timeout.
                        timeout_reg <= hold_expired & ~done & owner_req;
                    end else begin
                        cnt_reg     <= cnt_reg + 1'b1;
                        timeout_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign gnt_idx   = idx_reg;
    assign gnt_valid = valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_grant_indexer.sv
// Self-checking bench for rr_grant_indexer: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_rr_grant_indexer;

    localparam int HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner, cycles held so far, last winner.
    bit m_valid;
    bit m_to;
    int m_idx;
    int m_last;
    int m_held;

    rr_grant_indexer #(.HOLD_MAX(HOLD_MAX), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        int c;
        if (rst) begin
            m_valid = 0; m_to = 0; m_idx = 0; m_last = 3; m_held = 0;
        end else if (m_valid) begin
            if (done || !req[m_idx] || m_held >= HOLD_MAX) begin
                m_to    = (m_held == HOLD_MAX) && !done && req[m_idx];
                m_valid = 0;
                m_held  = 0;
            end else begin
                m_held = m_held + 1;
                m_to   = 0;
            end
        end else begin
            m_to = 0;
            if (req != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last + k) % 4;
                    if (req[c]) break;
                end
                m_valid = 1; m_idx = c; m_last = c; m_held = 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req = 4'b1111; done = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({gnt_valid, gnt_idx, timeout} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got v=%b i=%0d t=%b want v=0 i=0 t=0",
                         i, gnt_valid, gnt_idx, timeout);
            end
        end
        rst = 0;
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant: got v=%b i=%0d want v=1 i=0", gnt_valid, gnt_idx);
        end
        $display("reset: first grant idx=%0d", gnt_idx);
    endtask

    task automatic test_rotation();
        rst = 1; req = 4'b1111; done = 0;
        tick();
        rst = 0;
        for (int g = 0; g < 5; g++) begin
            tick();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 2'(g % 4)) begin
                errors++;
                $display("FAIL rotation_grant %0d: got v=%b i=%0d want v=1 i=%0d",
                         g, gnt_valid, gnt_idx, g % 4);
            end
            tick();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 2'(g % 4)) begin
                errors++;
                $display("FAIL rotation_hold %0d: got v=%b i=%0d want v=1 i=%0d",
                         g, gnt_valid, gnt_idx, g % 4);
            end
            done = 1;
            tick();
            done = 0;
            checks++;
            if (gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 2'(g % 4)) begin
                errors++;
                $display("FAIL rotation_bubble %0d: got v=%b t=%b i=%0d want v=0 t=0 i=%0d",
                         g, gnt_valid, timeout, gnt_idx, g % 4);
            end
            $display("rotation: grant %0d idx=%0d", g, g % 4);
        end
    endtask

    task automatic test_skip_wrap();
        logic [1:0] want [3];
        want[0] = 2'd3; want[1] = 2'd1; want[2] = 2'd3;
        rst = 1; req = 4'b0010; done = 0;
        tick();
        rst = 0;
        tick();                  // grant 1, last becomes 1
        done = 1;
        tick();
        done = 0; req = 4'b1010;
        for (int g = 0; g < 3; g++) begin
            tick();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== want[g]) begin
                errors++;
                $display("FAIL skip_wrap %0d: got v=%b i=%0d want v=1 i=%0d",
                         g, gnt_valid, gnt_idx, want[g]);
            end
            $display("skip_wrap: grant idx=%0d", gnt_idx);
            done = 1;
            tick();
            done = 0;
        end
    endtask

    task automatic test_timeout();
        rst = 1; req = 4'b0100; done = 0;
        tick();
        rst = 0;
        for (int c = 0; c < HOLD_MAX; c++) begin
            tick();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold cycle %0d: got v=%b i=%0d t=%b want v=1 i=2 t=0",
                         c, gnt_valid, gnt_idx, timeout);
            end
        end
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b1 || gnt_idx !== 2'd2) begin
            errors++;
            $display("FAIL timeout_pulse: got v=%b t=%b i=%0d want v=0 t=1 i=2",
                     gnt_valid, timeout, gnt_idx);
        end
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || timeout !== 1'b0 || gnt_idx !== 2'd2) begin
            errors++;
            $display("FAIL timeout_regrant: got v=%b t=%b i=%0d want v=1 t=0 i=2",
                     gnt_valid, timeout, gnt_idx);
        end
        $display("timeout: idx=2 held %0d cycles then regranted", HOLD_MAX);
    endtask

    task automatic test_simultaneous();
        rst = 1; req = 4'b0100; done = 0;
        tick();
        rst = 0;
        tick();                  // first grant cycle
        for (int c = 1; c < HOLD_MAX; c++) tick();
        done = 1;                // coincides with the last allowed cycle
        tick();
        done = 0;
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_at_limit: got v=%b t=%b want v=0 t=0", gnt_valid, timeout);
        end
        tick();                  // regrant
        tick();                  // middle cycle
        req = 4'b0000;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 2'd2) begin
            errors++;
            $display("FAIL withdraw: got v=%b t=%b i=%0d want v=0 t=0 i=2",
                     gnt_valid, timeout, gnt_idx);
        end
        $display("simultaneous: done-at-limit and withdraw releases");
    endtask

    task automatic test_reset_mid_grant();
        rst = 1; req = 4'b1111; done = 0;
        tick();
        rst = 0;
        for (int g = 0; g < 2; g++) begin
            tick();
            done = 1;
            tick();
            done = 0;
        end
        tick();                  // grant to 2, cycle 1
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2) begin
            errors++;
            $display("FAIL mid_grant_setup: got v=%b i=%0d want v=1 i=2", gnt_valid, gnt_idx);
        end
        tick();
        tick();                  // cycle 3
        rst = 1;
        tick();
        checks++;
        if ({gnt_valid, gnt_idx, timeout} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_grant_reset: got v=%b i=%0d t=%b want v=0 i=0 t=0",
                     gnt_valid, gnt_idx, timeout);
        end
        rst = 0;
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL mid_grant_restart: got v=%b i=%0d want v=1 i=0", gnt_valid, gnt_idx);
        end
        $display("reset_mid_grant: restart idx=%0d", gnt_idx);
    endtask

    task automatic test_random();
        bit prev_valid = 0;
        rst = 1; req = 4'b0000; done = 0;
        tick();
        rst = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 2) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 6) == 0);
            rst  = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if (gnt_valid !== m_valid || timeout !== m_to || gnt_idx !== 2'(m_idx)) begin
                errors++;
                $display("FAIL random cycle %0d: got v=%b i=%0d t=%b want v=%b i=%0d t=%b",
                         c, gnt_valid, gnt_idx, timeout, m_valid, m_idx, m_to);
            end
            if (gnt_valid && !prev_valid)
                $display("random: cycle %0d grant idx=%0d req=%b", c, gnt_idx, req);
            prev_valid = gnt_valid;
        end
        rst = 0;
    endtask

    initial begin
        m_valid = 0; m_to = 0; m_idx = 0; m_last = 3; m_held = 0;
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_timeout();
        test_simultaneous();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
